bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Upstream control stage of the two-master / three-slave serial system bus.
- Arbitrates bus requests from master 1 and master 2 and drives bus_grant to the master-side mux.
- Decodes the serial slave-select bits sent by the granted master and drives slave_grant to the slave-side mux.
- Holds the connection until the granted master releases its request.

Parameters:
- ADDR_TIMEOUT, 16: max cycles the granted master may leave master_valid low during the address phase before its grant is revoked; legal range 1..255.
- SLAVE_ID_BITS, 2: number of leading serial address bits that form the slave id; fixed at 2 for the 3-slave map.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- m1_request  input  1  master 1 bus request, level, held for the whole transaction
- m2_request  input  1  master 2 bus request
- m1_master_valid  input  1  master 1 serial bit valid
- m2_master_valid  input  1  master 2 serial bit valid
- m1_tx_address  input  1  master 1 serial address, MSB first
- m2_tx_address  input  1  master 2 serial address, MSB first
- bus_grant  output  2  00 none, 01 master 1, 10 master 2; 11 never driven
- slave_grant  output  3  one-hot: 001 slave 1, 010 slave 2, 100 slave 3, 000 none
- addr_err  output  1  one-cycle pulse: decoded slave id 00
- timeout  output  1  one-cycle pulse: address phase timed out
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; bus_grant=00, slave_grant=000, addr_err=0, timeout=0, busy=0; id shift register, bit counter and timer cleared; round-robin pointer set to master 1.
- All outputs are registered.
- IDLE:
  - Request sampled at edge N -> bus_grant valid after edge N, state ADDR, counter=0, timer=0.
  - Both requesting: master 1 wins (fixed priority, unless the optional feature is enabled).
- ADDR:
  - Each cycle the selected master's master_valid=1, its tx_address is shifted into id (MSB first) and the counter increments. The timer is reset to 0.
  - When the SLAVE_ID_BITS-th bit is sampled:
    - id 01/10/11 -> slave_grant=001/010/100 after that edge; state CONNECT.
    - id 00 -> addr_err=1 for one cycle; bus_grant=00; state IDLE.
  - Cycle with master_valid=0: timer increments. Reaching ADDR_TIMEOUT -> timeout=1 for one cycle; bus_grant=00; state IDLE.
  - Granted master drops its request -> IDLE at the next edge, outputs cleared, no error pulse.
  - Non-granted master's signals are ignored.
- CONNECT:
  - bus_grant and slave_grant held stable.
  - Granted master's request low at edge N -> bus_grant=00 and slave_grant=000 after edge N; state IDLE.
- Re-arbitration: always passes through IDLE. There is a minimum one-cycle gap with bus_grant=00 between two grants, so the master-side mux never switches masters mid-transaction.
- A pending request from the other master is serviced from IDLE on the following edge.
- Reset asserted mid-transaction: immediate return to reset values. No partial grant persists.
- busy=1 in ADDR and CONNECT.

Optional Feature:
- Macro: BUS_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests in IDLE, the master indicated by the round-robin pointer wins.
  - The pointer flips to the other master each time a grant is issued.
  - A single requester is always granted regardless of the pointer.
- Undefined: fixed priority, master 1 always wins ties. Pointer logic is not synthesised.

Test Plan:
- Reset, then m1_request=1, m1 sends valid bits 1,0 -> bus_grant=01 one cycle after request; slave_grant=010 one cycle after the second bit; busy=1.
- In CONNECT, drop m1_request -> next cycle bus_grant=00, slave_grant=000, busy=0.
- m1_request and m2_request rise in the same cycle, fixed priority -> bus_grant=01. After m1 releases, bus_grant=00 for one cycle, then 10.
- Same stimulus with BUS_ARBITER_ROUND_ROBIN_EN -> first grant 01, next tie won by m2 (10), following tie won by m1 (01).
- m2 granted, sends bits 0,0 -> addr_err=1 for exactly one cycle, bus_grant=00, slave_grant stays 000.
- m1 granted, master_valid held 0 for 16 cycles (ADDR_TIMEOUT=16) -> timeout pulses on the 16th, bus_grant=00. Separately, rst asserted in CONNECT -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master / three-slave bus arbiter: grants a master, decodes its serial slave id,
// holds the connection until release. Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin ties.
module bus_arbiter #(
  parameter int ADDR_TIMEOUT  = 16,
  parameter int SLAVE_ID_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_master_valid,
  input  logic       m2_master_valid,
  input  logic       m1_tx_address,
  input  logic       m2_tx_address,
  output logic [1:0] bus_grant,
  output logic [2:0] slave_grant,
  output logic       addr_err,
  output logic       timeout,
  output logic       busy
);
  localparam int CW = $clog2(SLAVE_ID_BITS + 1);

  typedef enum logic [1:0] {IDLE, ADDR, CONNECT} state_t;

  state_t                   state;
  logic [SLAVE_ID_BITS-1:0] id;
  logic [SLAVE_ID_BITS-1:0] id_next;
  logic [CW-1:0]            bit_cnt;
  logic [7:0]               timer;
  logic                     sel_req, sel_vld, sel_tx;
  logic                     any_req, grant_m2;

  // Only the granted master's lines are looked at outside IDLE.
  always_comb begin
    sel_req = bus_grant[1] ? m2_request      : m1_request;
    sel_vld = bus_grant[1] ? m2_master_valid : m1_master_valid;
    sel_tx  = bus_grant[1] ? m2_tx_address   : m1_tx_address;
    id_next = {id[SLAVE_ID_BITS-2:0], sel_tx};
  end

  assign any_req = m1_request | m2_request;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic rr_ptr;  // 0: master 1 wins the next tie, 1: master 2

  assign grant_m2 = m2_request & (~m1_request | rr_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rr_ptr <= 1'b0;
    else if (state == IDLE && any_req) rr_ptr <= ~rr_ptr;
  end
`else
  assign grant_m2 = m2_request & ~m1_request;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus_grant   <= 2'b00;
      slave_grant <= 3'b000;
      addr_err    <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      id          <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
    end else begin
      addr_err <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus_grant <= grant_m2 ? 2'b10 : 2'b01;
            state     <= ADDR;
            busy      <= 1'b1;
            id        <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
          end
        end
        ADDR: begin
          if (!sel_req) begin
            state     <= IDLE;
            bus_grant <= 2'b00;
            busy      <= 1'b0;
          end else if (sel_vld) begin
            id      <= id_next;
            bit_cnt <= bit_cnt + 1'b1;
            timer   <= '0;
            if (bit_cnt == CW'(SLAVE_ID_BITS - 1)) begin
              state <= CONNECT;
              case (id_next)
                2'd1:    slave_grant <= 3'b001;
                2'd2:    slave_grant <= 3'b010;
                2'd3:    slave_grant <= 3'b100;
                default: begin
                  // id 00 maps to no slave: drop the grant and flag it
                  state     <= IDLE;
                  addr_err  <= 1'b1;
                  bus_grant <= 2'b00;
                  busy      <= 1'b0;
                end
              endcase
            end
          end else if (timer == 8'(ADDR_TIMEOUT - 1)) begin
            state     <= IDLE;
            timeout   <= 1'b1;
            bus_grant <= 2'b00;
            busy      <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        CONNECT: begin
          if (!sel_req) begin
            state       <= IDLE;
            bus_grant   <= 2'b00;
            slave_grant <= 3'b000;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus_grant   <= 2'b00;
          slave_grant <= 3'b000;
          busy        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios, then random transactions checked against
// a transaction-level expectation of grant, slave select and error pulses.
module tb_bus_arbiter;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:1] req = '0, vld = '0, tx = '0;
  logic [1:0] bus_grant;
  logic [2:0] slave_grant;
  logic       addr_err, timeout, busy;

  int total = 0;
  int bad   = 0;
  int exp_ptr = 1;  // master that wins the next tie when round-robin is built in

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_TIMEOUT(TO), .SLAVE_ID_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .m1_request(req[1]), .m2_request(req[2]),
    .m1_master_valid(vld[1]), .m2_master_valid(vld[2]),
    .m1_tx_address(tx[1]), .m2_tx_address(tx[2]),
    .bus_grant(bus_grant), .slave_grant(slave_grant),
    .addr_err(addr_err), .timeout(timeout), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int bg, input int sg,
                         input int ae, input int to, input int bz);
    chk({tag, ".bus_grant"},   8'(bus_grant),   8'(bg));
    chk({tag, ".slave_grant"}, 8'(slave_grant), 8'(sg));
    chk({tag, ".addr_err"},    8'(addr_err),    8'(ae));
    chk({tag, ".timeout"},     8'(timeout),     8'(to));
    chk({tag, ".busy"},        8'(busy),        8'(bz));
  endtask

  function automatic int tie_winner();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    return exp_ptr;
`else
    return 1;
`endif
  endfunction

  function automatic int slave_of(input logic [1:0] id);
    case (id)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  // One transaction by master m from an idle bus. gapN = idle cycles before bit N;
  // abort drops the request after the first bit.
  task automatic txn(input int m, input logic [1:0] id, input int gap0, input int gap1,
                     input int hold, input bit abort);
    int o;
    int gap;
    o = 3 - m;
    req[m] = 1'b1;
    tick();
    exp_ptr = 3 - exp_ptr;
    chk_out("grant", m, 0, 0, 0, 1);
    for (int b = 0; b < 2; b++) begin
      gap = (b == 0) ? gap0 : gap1;
      for (int g = 0; g < gap; g++) begin
        vld[m] = 1'b0; tx[m] = 1'($urandom);
        vld[o] = 1'($urandom); tx[o] = 1'($urandom);
        tick();
        if (g + 1 == TO) begin
          chk_out("timeout", 0, 0, 0, 1, 0);
          req[m] = 1'b0; vld = '0;
          tick();
          chk_out("timeout_clear", 0, 0, 0, 0, 0);
          return;
        end
        chk_out("addr_wait", m, 0, 0, 0, 1);
      end
      vld[m] = 1'b1; tx[m] = id[1-b];
      tick();
      vld = '0;
      if (b == 0) begin
        chk_out("bit0", m, 0, 0, 0, 1);
        if (abort) begin
          req[m] = 1'b0;
          tick();
          chk_out("abort", 0, 0, 0, 0, 0);
          return;
        end
      end
    end
    if (id == 2'b00) begin
      chk_out("addr_err", 0, 0, 1, 0, 0);
      req[m] = 1'b0;
      tick();
      chk_out("addr_err_clear", 0, 0, 0, 0, 0);
      return;
    end
    chk_out("connect", m, slave_of(id), 0, 0, 1);
    for (int h = 0; h < hold; h++) begin
      vld[o] = 1'($urandom); tx[o] = 1'($urandom); tx[m] = 1'($urandom);
      tick();
      chk_out("hold", m, slave_of(id), 0, 0, 1);
    end
    vld = '0;
    req[m] = 1'b0;
    tick();
    chk_out("release", 0, 0, 0, 0, 0);
  endtask

  // Both masters request together; winner sends id 11. If keep_loser, the loser
  // stays requesting and must be granted after a one-cycle gap.
  task automatic tie(input bit keep_loser);
    int w;
    int l;
    req = 2'b11;
    tick();
    w = tie_winner();
    l = 3 - w;
    exp_ptr = 3 - exp_ptr;
    chk_out("tie_grant", w, 0, 0, 0, 1);
    vld = 2'b11; tx = 2'b11;
    tick();
    tick();
    vld = '0;
    chk_out("tie_connect", w, 4, 0, 0, 1);
    req[w] = 1'b0;
    if (!keep_loser) req[l] = 1'b0;
    tick();
    chk_out("tie_gap", 0, 0, 0, 0, 0);
    if (keep_loser) begin
      tick();
      exp_ptr = 3 - exp_ptr;
      chk_out("loser_grant", l, 0, 0, 0, 1);
      vld[l] = 1'b1; tx[l] = 1'b0;
      tick();
      tx[l] = 1'b1;
      tick();
      vld = '0;
      chk_out("loser_connect", l, 1, 0, 0, 1);
      req[l] = 1'b0;
      tick();
      chk_out("loser_release", 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick(); tick();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_out("idle", 0, 0, 0, 0, 0);

    // m1 sends 1,0 -> slave 2
    txn(1, 2'b10, 0, 0, 3, 1'b0);

    // ties: first with pending loser, then three clean ties
    tie(1'b1);
    tie(1'b0);
    tie(1'b0);
    tie(1'b0);

    // id 00 from m2
    txn(2, 2'b00, 0, 0, 0, 1'b0);
    // timeout boundary: 15 idle cycles is fine, 16 times out
    txn(1, 2'b11, TO - 1, TO - 1, 1, 1'b0);
    txn(1, 2'b01, TO, 0, 0, 1'b0);
    txn(2, 2'b01, 2, TO, 0, 1'b0);
    // drop request mid-address
    txn(2, 2'b11, 1, 0, 0, 1'b1);

    // asynchronous reset in CONNECT
    req[2] = 1'b1;
    tick();
    exp_ptr = 3 - exp_ptr;
    vld[2] = 1'b1; tx[2] = 1'b0;
    tick();
    tx[2] = 1'b1;
    tick();
    vld = '0;
    chk_out("pre_rst_connect", 2, 1, 0, 0, 1);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0);
    req = '0;
    tick();
    rst = 1'b0;
    exp_ptr = 1;
    tick();
    chk_out("post_rst", 0, 0, 0, 0, 0);

    // random single-master transactions
    for (int n = 0; n < 40; n++) begin
      int m, g0, g1, hold;
      logic [1:0] id;
      bit ab;
      m    = 1 + int'($urandom_range(0, 1));
      id   = 2'($urandom);
      g0   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 3));
      g1   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 4));
      ab   = ($urandom_range(0, 7) == 0);
      txn(m, id, g0, g1, hold, ab);
    end

    // one more tie after the random run exercises the pointer state it left
    tie(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end
endmodule
